mipsl_fetch: RTL
================

MIPSL_FETCH -- requirements
Module: mipsl_fetch

Interface
REQ-001 Parameters SHALL be one per line as name, default, meaning:
  RESET_PC, 16'h0000, PC value loaded on reset.
  NOP_INSTR, 16'h0000, bubble instruction, add $0,$0,$0 (opcode 0).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 Ports SHALL be one per line as name, direction, width, meaning:
  clock  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  imem_req  out  1  instruction memory request
  imem_addr  out  16  byte address = pc
  imem_ack  in  1  imem_rdata valid this cycle; sampled only while imem_req=1
  imem_rdata  in  16  fetched instruction
  stall  in  1  hold the IF/ID register (hazard unit)
  branch_taken  in  1  redirect the PC (from the EX stage)
  branch_target  in  16  redirect address
  pc  out  16  current fetch PC
  id_valid  out  1  IF/ID holds a real instruction
  id_instr  out  16  IF/ID instruction
  id_pc_plus2  out  16  address of id_instr + 2
  id_opcode  out  3  id_instr[15:13]; drives the control unit opcode input

Function
REQ-004 The FSM SHALL have three states: S_IDLE, S_REQ and S_HOLD.
REQ-005 S_IDLE SHALL drive imem_req=0 and go to S_REQ on the next cycle.
REQ-006 S_REQ SHALL drive imem_req=1 and imem_addr=pc, combinationally.
REQ-007 In S_REQ with imem_ack=1, stall=0 and branch_taken=0, the block SHALL:
  - load id_instr<=imem_rdata, id_pc_plus2<=pc+2 and id_valid<=1;
  - update pc<=pc+2;
  - stay in S_REQ.
REQ-008 In S_REQ with imem_ack=1 and stall=1, the block SHALL:
  - capture imem_rdata and pc+2 into a one-entry holding buffer;
  - update pc<=pc+2;
  - leave IF/ID unchanged and go to S_HOLD.
REQ-009 In S_REQ with imem_ack=0 and stall=0, the block SHALL insert a bubble: id_valid<=0, id_instr<=NOP_INSTR, pc unchanged.
REQ-010 In S_REQ with imem_ack=0 and stall=1, IF/ID and pc SHALL hold.
REQ-011 S_HOLD SHALL drive imem_req=0.
  - While stall=1, the buffer and IF/ID SHALL hold.
  - When stall=0, the buffer SHALL load into IF/ID with id_valid<=1, and the FSM SHALL go to S_REQ.
REQ-012 branch_taken=1 SHALL override stall and imem_ack in every state:
  - pc<=branch_target;
  - id_valid<=0 and id_instr<=NOP_INSTR;
  - holding buffer discarded;
  - any same-cycle imem_rdata dropped;
  - next state S_REQ.
REQ-013 PC arithmetic SHALL be modulo 2^16: pc=16'hFFFE increments to 16'h0000 with no error flag.
REQ-014 pc bit 0 SHALL be forced to 0; branch_target[0] SHALL be ignored.
REQ-015 With imem_ack tied to 1, the first instruction SHALL appear on id_instr on the second rising edge after reset deasserts, then one instruction per cycle.
REQ-016 id_opcode SHALL always equal id_instr[15:13], including during bubbles (opcode 0).
REQ-017 At most one instruction SHALL be buffered; no fetch SHALL be issued while the buffer is full.

Reset
REQ-018 Reset SHALL set:
  - pc=RESET_PC and state=S_IDLE;
  - id_valid=0, id_instr=NOP_INSTR, id_pc_plus2=16'h0000;
  - buffer empty and imem_req=0.
REQ-019 Reset SHALL take priority over branch_taken, stall and imem_ack.
REQ-020 Reset asserted mid-fetch or in S_HOLD SHALL discard all in-flight and buffered data.

Structure
REQ-021 Package mipsl_pkg SHALL hold the following, shared with the control unit and datapath:
  - OPCODE_W=3, INSTR_W=16 and NOP_INSTR;
  - the opcode constants (ADD=0, SUB=1, SLT=2, LW=3, SW=4, BEQ=5, ADDI=6, ANDI=7);
  - the fetch state enum.
REQ-022 The IF/ID register plus its holding buffer SHALL be one sub-module, mipsl_ifid_reg; the PC and FSM SHALL stay in mipsl_fetch.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  - Reset; imem_ack=1, imem_rdata=16'h2A50 -> 2nd edge: id_instr=16'h2A50, id_opcode=1, id_pc_plus2=2, id_valid=1.
  - Steady ack; stall=1 for 3 cycles at pc=6 -> IF/ID unchanged; pc=8; after release the buffered instr at addr 6 issues, then fetch resumes at 8.
  - branch_taken=1, branch_target=16'h0041 together with stall=1 and imem_ack=1 -> pc=16'h0040, id_valid=0, id_instr=0, state S_REQ.
  - imem_ack=0 for 2 cycles, stall=0 -> two bubbles (id_valid=0, id_opcode=0); pc holds.
  - pc=16'hFFFE with ack -> pc=16'h0000, id_pc_plus2=16'h0000.
  - Reset during S_HOLD -> all outputs at reset values next cycle; buffered instruction never issues.

Source files
------------

// File: rtl/mipsl_pkg.sv
// Shared definitions for the MIPS-lite fetch stage, control unit and datapath.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mipsl_pkg;

  localparam int OPCODE_W = 3;
  localparam int INSTR_W  = 16;

  // add $0,$0,$0 -- opcode 0, all fields zero
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [OPCODE_W-1:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    SLT  = 3'd2,
    LW   = 3'd3,
    SW   = 3'd4,
    BEQ  = 3'd5,
    ADDI = 3'd6,
    ANDI = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // One fetched instruction together with its return address
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus2;
  } ifid_ent_t;

  // Instructions are halfword aligned; bit 0 of any address is dropped
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] a);
    return {a[INSTR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/mipsl_ifid_reg.sv
// IF/ID pipeline register with a one-entry holding buffer for a fetch that lands during a stall.
// Latency: one cycle from load/issue strobe to the IF/ID outputs.
// Backpressure: buffer absorbs exactly one instruction; buf_full tells the fetch FSM to stop requesting.
module mipsl_ifid_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 load_mem,
  input  logic                                 buf_load,
  input  logic                                 buf_issue,
  input  logic                                 bubble,
  input  logic [mipsl_pkg::INSTR_W-1:0]        mem_instr,
  input  logic [mipsl_pkg::INSTR_W-1:0]        mem_pc_plus2,
  output logic                                 buf_full,
  output logic                                 id_valid,
  output logic [mipsl_pkg::INSTR_W-1:0]        id_instr,
  output logic [mipsl_pkg::INSTR_W-1:0]        id_pc_plus2,
  output logic [mipsl_pkg::OPCODE_W-1:0]       id_opcode
);
  import mipsl_pkg::*;

  ifid_ent_t hold_ent;

  // Opcode decode follows the register directly so bubbles read as opcode 0
  assign id_opcode = id_instr[INSTR_W-1 -: OPCODE_W];

  // Flush beats everything but reset; a pending buffered entry issues before any new fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc_plus2 <= '0;
      buf_full    <= 1'b0;
      hold_ent    <= '{instr: NOP_INSTR, pc_plus2: '0};
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      buf_full <= 1'b0;
    end else if (buf_issue) begin
      id_valid    <= 1'b1;
      id_instr    <= hold_ent.instr;
      id_pc_plus2 <= hold_ent.pc_plus2;
      buf_full    <= 1'b0;
    end else if (load_mem) begin
      id_valid    <= 1'b1;
      id_instr    <= mem_instr;
      id_pc_plus2 <= mem_pc_plus2;
    end else if (buf_load) begin
      buf_full <= 1'b1;
      hold_ent <= '{instr: mem_instr, pc_plus2: mem_pc_plus2};
    end else if (bubble) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/mipsl_fetch.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID register for the MIPS-lite core.
// Latency: first instruction reaches IF/ID on the 2nd edge after reset, then one per acked cycle.
// Backpressure: stall parks one in-flight fetch in the holding buffer and suppresses imem_req until released.
module mipsl_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  output logic                                 imem_req,
  output logic [mipsl_pkg::INSTR_W-1:0]        imem_addr,
  input  logic                                 imem_ack,
  input  logic [mipsl_pkg::INSTR_W-1:0]        imem_rdata,
  input  logic                                 stall,
  input  logic                                 branch_taken,
  input  logic [mipsl_pkg::INSTR_W-1:0]        branch_target,
  output logic [mipsl_pkg::INSTR_W-1:0]        pc,
  output logic                                 id_valid,
  output logic [mipsl_pkg::INSTR_W-1:0]        id_instr,
  output logic [mipsl_pkg::INSTR_W-1:0]        id_pc_plus2,
  output logic [mipsl_pkg::OPCODE_W-1:0]       id_opcode
);
  import mipsl_pkg::*;

  fetch_state_e             state;
  logic                     buf_full;
  logic                     fetching;
  logic                     accept;
  logic                     load_mem;
  logic                     buf_load;
  logic                     buf_issue;
  logic                     bubble;
  logic [INSTR_W-1:0]       pc_plus2;

  // Request only from S_REQ; the buffer check keeps a full buffer from ever being overrun
  assign fetching  = (state == S_REQ) && !buf_full;
  assign imem_req  = fetching;
  assign imem_addr = pc;
  assign pc_plus2  = pc + 16'd2;

  // Decode the cycle's IF/ID action; branch_taken squashes any same-cycle data
  assign accept    = fetching && imem_ack && !branch_taken;
  assign load_mem  = accept && !stall;
  assign buf_load  = accept && stall;
  assign buf_issue = (state == S_HOLD) && !stall && !branch_taken;
  assign bubble    = fetching && !imem_ack && !stall && !branch_taken;

  // PC and fetch FSM: reset, then redirect, then normal sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= align_pc(RESET_PC);
    end else if (branch_taken) begin
      state <= S_REQ;
      pc    <= align_pc(branch_target);
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (accept) begin
            pc <= pc_plus2;
            if (stall) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mipsl_ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clock        (clock),
    .reset        (reset),
    .flush        (branch_taken),
    .load_mem     (load_mem),
    .buf_load     (buf_load),
    .buf_issue    (buf_issue),
    .bubble       (bubble),
    .mem_instr    (imem_rdata),
    .mem_pc_plus2 (pc_plus2),
    .buf_full     (buf_full),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc_plus2  (id_pc_plus2),
    .id_opcode    (id_opcode)
  );

endmodule
